aac_feeder: RTL and testbench
=============================

# aac_feeder

Upstream operand stage for the `AAC` accumulator. Accepts signed operand pairs over a valid/ready handshake and forms their product in a registered multiply stage. It drives the product and the load/accumulate control into `AAC`, frames every `LEN` products into one dot product, and captures the accumulator result into a handshaked output register.

## Interface

Parameters:
- `DW`, 12, signed operand width
- `AW`, 24, product / accumulator width (must be ≥ 2·`DW`)
- `LEN`, 8, products per frame (≥ 1)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid_i`  in  1  operand pair valid
- `in_ready_o`  out  1  operand pair accepted when `in_valid_i && in_ready_o`
- `x_i`  in  `DW`  signed operand
- `w_i`  in  `DW`  signed operand
- `A_o`  out  `AW`  signed product, to `AAC.A_i`
- `aac_o`  out  1  to `AAC.aac`: 0 = load `A_o`, 1 = accumulate `A_o`
- `acc_i`  in  `AW`  signed accumulator value, from `AAC.out`
- `res_valid_o`  out  1  frame result valid
- `res_ready_i`  in  1  result consumed when `res_valid_o && res_ready_i`
- `res_o`  out  `AW`  signed frame result (dot product of `LEN` pairs)

## Operation

- Multiply: `A_o` is registered `x_i * w_i`, full-precision signed, sign-extended to `AW`; no rounding, no saturation.
- Accumulator contract: `AAC` registers every cycle.
  - `aac_o=0` means acc ← `A_o`.
  - `aac_o=1` means acc ← acc + `A_o`.
  - Overflow wraps inside `AAC`; this block does not check it.
- Term counter `cnt`, range 0..`LEN`-1.
  - Incremented on each accepted pair; wraps to 0 after `LEN`-1.
- Issued term drive:
  - First term of a frame (`cnt==0` at acceptance): `aac_o=0`.
  - Later terms: `aac_o=1`.
- Idle cycles (no pair accepted on the previous edge): `A_o=0`, `aac_o=1`, so `AAC` holds.
- Capture FSM, states `RUN` and `CAPT`:
  - `RUN` → `CAPT` on the edge that accepts the last pair (`cnt==LEN-1`).
  - `CAPT` → `RUN` after one cycle. On that exit edge, `acc_i` is written to `res_o` and `res_valid_o` is set.
  - `res_valid_o` clears on the handshake edge, unless a new capture occurs on the same edge; in that case it stays 1 with the new value.
- Back-pressure: `in_ready_o = !(cnt==LEN-1 && res_valid_o && !res_ready_i)`.
  - The last pair of a frame is held off only while an unconsumed result occupies the result register.
  - All other pairs are never stalled.
- Next frame: its first pair may be accepted on the edge immediately after the last pair. Its load reaches `AAC` in the same cycle that `CAPT` samples `acc_i`. This is legal because `acc_i` still holds the previous frame's total.
- `LEN=1`: every pair is both first and last (`aac_o=0`) and produces one result.

## Timing

- Reset values (applied at the edge with `reset=1`):
  - `A_o=0`, `aac_o=1`
  - `res_o=0`, `res_valid_o=0`
  - `cnt=0`, state `RUN`
  - `in_ready_o=1` after reset.
- Pair accepted at edge t:
  - `A_o`/`aac_o` are valid in cycle t→t+1.
  - `AAC` updates at edge t+1.
- Last pair accepted at edge t: `acc_i` is sampled at edge t+2, and `res_valid_o=1` from t+2.
- Throughput: one pair per cycle; a frame of `LEN` pairs takes `LEN` cycles when the result is drained.
- Reset mid-frame:
  - Partial frame discarded; pending `CAPT` cancelled; result register cleared.
  - The first pair after reset is a load (`aac_o=0`).
  - `AAC` is not required to be reset: the load overwrites it.

## Structure

- Shared package `aac_pkg`:
  - Default `DW`/`AW`.
  - Constants `AAC_LOAD=1'b0` and `AAC_ACC=1'b1`.
  - FSM state enum `{RUN, CAPT}`.
- Sub-module `aac_mul_stage`: registered signed `DW×DW→AW` multiplier with its valid flag (zeroes `A_o` when not valid).
- Top holds the counter, back-pressure, capture FSM and result register.
- The bench instantiates `aac_feeder` with the real `AAC` behind it.

## Test plan

- Basic frame: `LEN=4`, x=1,2,3,4, w=10,20,30,40 back-to-back, `res_ready_i=1` → `aac_o` sequence 0,1,1,1; `res_o=300`; `res_valid_o` high exactly 2 cycles after the 4th accept.
- Corner products: `LEN=2`, pairs (−2048,−2048), (−2048,2047) → `res_o` = 4194304 − 4192256 = 2048; `A_o` values sign-correct.
- Idle gaps: `LEN=4`, one idle cycle between each pair → `A_o=0`, `aac_o=1` on gap cycles; result still 300.
- Back-pressure: two back-to-back frames (results 300 and 600), `res_ready_i=0` → `in_ready_o` drops only at the second frame's last pair; `res_o` stays 300 until drained; raising `res_ready_i` yields 300 then 600, nothing lost.
- Reset mid-frame: reset asserted after 2 of 4 pairs, then a full frame x=1..4, w=1 → `res_o=10`; no result emitted for the aborted frame.
- `LEN=1`: stream x=5,−3, w=7,7 → `aac_o=0` every term; results 35, −21 on consecutive cycles.

Source files
------------

// File: rtl/aac_pkg.sv
// aac_pkg: shared definitions for the AAC operand feeder.
// Holds default widths, the load/accumulate control encoding seen by AAC,
// the capture FSM state type and a counter-width helper.
package aac_pkg;

  // Default operand / product widths and frame length.
  localparam int AAC_DW  = 12;
  localparam int AAC_AW  = 24;
  localparam int AAC_LEN = 8;

  // AAC control encoding: LOAD overwrites the accumulator, ACC adds to it.
  localparam logic AAC_LOAD = 1'b0;
  localparam logic AAC_ACC  = 1'b1;

  // Result capture FSM.
  typedef enum logic {
    RUN  = 1'b0,
    CAPT = 1'b1
  } aac_state_e;

  // Width of a counter spanning 0..len-1; a length of 1 still needs one bit.
  function automatic int aac_cnt_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/aac_mul_stage.sv
// aac_mul_stage: registered signed DW x DW -> AW multiplier with AAC control.
// Latency 1 cycle; no backpressure (a valid term is issued every cycle it is given).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   vld_i              an accepted operand pair is present this cycle
//   x_i, w_i           signed operands
//   load_i             the pair is the first term of a frame
//   last_i             the pair is the last term of a frame
//   A_o                registered product, zero when no term was issued
//   aac_o              registered AAC control (LOAD for first term, else ACC)
//   last_o             registered flag: A_o carries the last term of a frame
module aac_mul_stage
  import aac_pkg::*;
#(
  parameter int DW = AAC_DW,
  parameter int AW = AAC_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_i,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] w_i,
  input  logic          load_i,
  input  logic          last_i,
  output logic [AW-1:0] A_o,
  output logic          aac_o,
  output logic          last_o
);

  logic [AW-1:0] x_ext;
  logic [AW-1:0] w_ext;
  logic [AW-1:0] prod;

  logic [AW-1:0] A_q, A_d;
  logic          aac_q, aac_d;
  logic          last_q, last_d;

  // Sign-extend both operands to AW first; because AW >= 2*DW the AW-bit
  // product is the exact full-precision signed result.
  assign x_ext = {{(AW - DW){x_i[DW-1]}}, x_i};
  assign w_ext = {{(AW - DW){w_i[DW-1]}}, w_i};
  assign prod  = $signed(x_ext) * $signed(w_ext);

  // With no term issued, drive 0 with ACC so the accumulator holds its value.
  always_comb begin
    A_d    = '0;
    aac_d  = AAC_ACC;
    last_d = 1'b0;
    if (vld_i) begin
      A_d    = prod;
      aac_d  = load_i ? AAC_LOAD : AAC_ACC;
      last_d = last_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      A_q    <= '0;
      aac_q  <= AAC_ACC;
      last_q <= 1'b0;
    end else begin
      A_q    <= A_d;
      aac_q  <= aac_d;
      last_q <= last_d;
    end
  end

  assign A_o    = A_q;
  assign aac_o  = aac_q;
  assign last_o = last_q;

endmodule

// File: rtl/aac_feeder.sv
// aac_feeder: operand stage in front of the AAC accumulator; frames LEN products
// into one dot product. Latency: product on A_o 1 cycle after accept, result valid
// 2 cycles after the last accept. Backpressure: only a frame's last pair stalls,
// and only while an unconsumed result occupies the result register.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid_i/in_ready_o         operand pair handshake, x_i/w_i signed operands
//   A_o, aac_o                    product and load/accumulate control to AAC
//   acc_i                         accumulator value from AAC
//   res_valid_o/res_ready_i       frame result handshake, res_o signed dot product
module aac_feeder
  import aac_pkg::*;
#(
  parameter int DW  = AAC_DW,
  parameter int AW  = AAC_AW,
  parameter int LEN = AAC_LEN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] w_i,
  output logic [AW-1:0] A_o,
  output logic          aac_o,
  input  logic [AW-1:0] acc_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [AW-1:0] res_o
);

  localparam int            CW       = aac_cnt_w(LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_first;
  logic          is_last;
  logic          accept;
  logic          last_issued;

  aac_state_e    state_q;
  logic          res_valid_q;
  logic [AW-1:0] res_q;

  // ---------------------------------------------------------------------------
  // Term counter and input back-pressure
  // ---------------------------------------------------------------------------
  assign is_first = (cnt_q == '0);
  assign is_last  = (cnt_q == CNT_LAST);

  // Holding off only the last pair is enough for LEN >= 3: the next capture
  // lands at least one edge after the gating decision sees the occupied
  // register. With LEN <= 2 captures can follow each other closely enough that
  // the consumer is expected to keep res_ready_i high.
  assign in_ready_o = !(is_last && res_valid_q && !res_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = is_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered multiply stage driving AAC
  // ---------------------------------------------------------------------------
  aac_mul_stage #(
    .DW (DW),
    .AW (AW)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .vld_i  (accept),
    .x_i    (x_i),
    .w_i    (w_i),
    .load_i (is_first),
    .last_i (is_last),
    .A_o    (A_o),
    .aac_o  (aac_o),
    .last_o (last_issued)
  );

  // ---------------------------------------------------------------------------
  // Capture FSM and result register
  // ---------------------------------------------------------------------------
  // The last product sits on A_o for one cycle and AAC absorbs it at the edge
  // that ends that cycle, so the FSM enters CAPT on that edge and samples
  // acc_i on the following one. A first term of the next frame issued
  // meanwhile only reaches AAC on that same sampling edge, so acc_i still
  // holds the finished total. Back-to-back last terms (LEN=1) keep the FSM in
  // CAPT and produce one capture per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      // A consumed result clears; a capture on the same edge overrides this.
      if (res_valid_q && res_ready_i) begin
        res_valid_q <= 1'b0;
      end
      case (state_q)
        RUN: begin
          if (last_issued) begin
            state_q <= CAPT;
          end
        end
        CAPT: begin
          res_q       <= acc_i;
          res_valid_q <= 1'b1;
          state_q     <= last_issued ? CAPT : RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;

endmodule

// File: tb/tb_aac_feeder.sv
// tb_aac_feeder: self-checking bench for aac_feeder with an AAC register behind
// each instance. Instance 0 uses LEN=4, instance 1 LEN=2, instance 2 LEN=1.
module tb_aac_feeder;
  import aac_pkg::*;

  localparam int DW = 12;
  localparam int AW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 in_valid  [3];
  logic                 in_ready  [3];
  logic signed [DW-1:0] x         [3];
  logic signed [DW-1:0] w         [3];
  logic signed [AW-1:0] a_o       [3];
  logic                 aac_o     [3];
  logic                 res_valid [3];
  logic                 res_ready [3];
  logic signed [AW-1:0] res_o     [3];

  int checks = 0;
  int errors = 0;

  function automatic int len_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [AW-1:0] acc_r;
      aac_feeder #(
        .DW  (DW),
        .AW  (AW),
        .LEN ((g == 0) ? 4 : ((g == 1) ? 2 : 1))
      ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid[g]),
        .in_ready_o  (in_ready[g]),
        .x_i         (x[g]),
        .w_i         (w[g]),
        .A_o         (a_o[g]),
        .aac_o       (aac_o[g]),
        .acc_i       (acc_r),
        .res_valid_o (res_valid[g]),
        .res_ready_i (res_ready[g]),
        .res_o       (res_o[g])
      );
      // AAC: registers every cycle, load or accumulate, wraps on overflow.
      always_ff @(posedge clk) begin
        acc_r <= (aac_o[g] == AAC_ACC) ? acc_r + a_o[g] : a_o[g];
      end
    end
  endgenerate

  task automatic chk(input string tag, input longint obs, input longint req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks accepted pairs, frame position and frame sums,
  // and where the result register should be, checked every cycle.
  // ---------------------------------------------------------------------------
  bit                   armed = 1'b0;
  bit                   m_prev_rst = 1'b0;
  bit                   m_prev_acc [3] = '{0, 0, 0};
  bit                   m_prev_hs  [3] = '{0, 0, 0};
  logic signed [DW-1:0] m_x [3];
  logic signed [DW-1:0] m_w [3];
  int                   m_cnt [3] = '{0, 0, 0};
  longint               m_sum [3] = '{0, 0, 0};
  bit                   cap_a [3] = '{0, 0, 0};
  bit                   cap_b [3] = '{0, 0, 0};
  logic signed [AW-1:0] cap_a_v [3];
  logic signed [AW-1:0] cap_b_v [3];
  bit                   e_valid [3] = '{0, 0, 0};
  logic signed [AW-1:0] e_res [3];
  int                   got_cnt  [3] = '{0, 0, 0};
  logic signed [AW-1:0] got_last [3];
  logic signed [AW-1:0] got_prev [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic signed [AW-1:0] exp_a;
      logic                 exp_aac;
      logic                 exp_rdy;
      longint               prod;
      exp_a   = '0;
      exp_aac = AAC_ACC;
      if (m_prev_rst) begin
        m_cnt[k]   = 0;
        cap_a[k]   = 1'b0;
        cap_b[k]   = 1'b0;
        e_valid[k] = 1'b0;
        e_res[k]   = '0;
        armed      = 1'b1;
      end else begin
        if (m_prev_hs[k]) e_valid[k] = 1'b0;
        if (cap_b[k]) begin
          e_valid[k] = 1'b1;
          e_res[k]   = cap_b_v[k];
        end
        cap_b[k]   = cap_a[k];
        cap_b_v[k] = cap_a_v[k];
        cap_a[k]   = 1'b0;
        if (m_prev_acc[k]) begin
          prod = longint'(m_x[k]) * longint'(m_w[k]);
          if (m_cnt[k] == 0) begin
            m_sum[k] = prod;
            exp_aac  = AAC_LOAD;
          end else begin
            m_sum[k] = m_sum[k] + prod;
          end
          exp_a    = AW'(prod);
          m_cnt[k] = (m_cnt[k] + 1) % len_of(k);
          if (m_cnt[k] == 0) begin
            cap_a[k]   = 1'b1;
            cap_a_v[k] = AW'(m_sum[k]);
          end
        end
      end
      exp_rdy = !((m_cnt[k] == len_of(k) - 1) && e_valid[k] && !res_ready[k]);
      if (armed) begin
        chk($sformatf("A_o[%0d]", k), a_o[k], exp_a);
        chk($sformatf("aac_o[%0d]", k), aac_o[k], exp_aac);
        chk($sformatf("res_valid[%0d]", k), res_valid[k], e_valid[k]);
        chk($sformatf("res_o[%0d]", k), res_o[k], e_res[k]);
        chk($sformatf("in_ready[%0d]", k), in_ready[k], exp_rdy);
      end
      m_prev_acc[k] = !reset && in_valid[k] && in_ready[k];
      m_x[k]        = x[k];
      m_w[k]        = w[k];
      m_prev_hs[k]  = !reset && res_valid[k] && res_ready[k];
      if (m_prev_hs[k]) begin
        got_cnt[k]++;
        got_prev[k] = got_last[k];
        got_last[k] = res_o[k];
      end
    end
    m_prev_rst = reset;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one pair and wait until it is accepted; after raise_after refused
  // cycles the consumer side of this instance is made ready.
  task automatic put(input int k, input int xv, input int wv, input int raise_after);
    bit ok;
    ok = 1'b0;
    in_valid[k] = 1'b1;
    x[k] = DW'(xv);
    w[k] = DW'(wv);
    for (int n = 0; n < 64 && !ok; n++) begin
      if (n >= raise_after) res_ready[k] = 1'b1;
      @(negedge clk);
      ok = in_ready[k];
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b0;
    chk($sformatf("accept[%0d]", k), ok, 1);
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    int c0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      x[k]         = '0;
      w[k]         = '0;
      res_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    for (int k = 0; k < 3; k++) begin
      chk("rst A_o", a_o[k], 0);
      chk("rst aac_o", aac_o[k], 1);
      chk("rst res_valid", res_valid[k], 0);
      chk("rst res_o", res_o[k], 0);
      chk("rst in_ready", in_ready[k], 1);
    end

    // Basic frame, LEN=4: aac_o 0,1,1,1 and result 300 two cycles after last.
    for (int i = 1; i <= 4; i++) begin
      put(0, i, 10 * i, 1000);
      chk("basic aac_o", aac_o[0], (i == 1) ? 0 : 1);
      chk("basic A_o", a_o[0], 10 * i * i);
    end
    chk("basic valid t+0", res_valid[0], 0);
    idle(1);
    chk("basic valid t+1", res_valid[0], 0);
    idle(1);
    chk("basic valid t+2", res_valid[0], 1);
    chk("basic res", res_o[0], 300);
    idle(3);

    // Idle gaps between pairs.
    for (int i = 1; i <= 4; i++) begin
      put(0, i, 10 * i, 1000);
      idle(1);
      chk("gap A_o", a_o[0], 0);
      chk("gap aac_o", aac_o[0], 1);
    end
    idle(4);
    chk("gap res", got_last[0], 300);

    // Back-pressure: two frames, consumer stalled.
    c0 = got_cnt[0];
    res_ready[0] = 1'b0;
    for (int i = 1; i <= 4; i++) put(0, i, 10 * i, 1000);
    for (int i = 1; i <= 3; i++) put(0, i, 20 * i, 1000);
    in_valid[0] = 1'b1;
    x[0] = DW'(4);
    w[0] = DW'(80);
    repeat (3) begin
      @(negedge clk);
      chk("bp in_ready", in_ready[0], 0);
      chk("bp res held", res_o[0], 300);
    end
    @(posedge clk);
    #1;
    put(0, 4, 80, 0);
    idle(6);
    chk("bp count", got_cnt[0] - c0, 2);
    chk("bp first", got_prev[0], 300);
    chk("bp second", got_last[0], 600);

    // Reset in the middle of a frame.
    c0 = got_cnt[0];
    put(0, 1, 1, 1000);
    put(0, 2, 1, 1000);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midrst A_o", a_o[0], 0);
    chk("midrst valid", res_valid[0], 0);
    for (int i = 1; i <= 4; i++) begin
      put(0, i, 1, 1000);
      if (i == 1) chk("midrst load", aac_o[0], 0);
    end
    idle(5);
    chk("midrst count", got_cnt[0] - c0, 1);
    chk("midrst res", got_last[0], 10);

    // Corner products, LEN=2.
    put(1, -2048, -2048, 1000);
    chk("corner A0", a_o[1], 4194304);
    chk("corner aac0", aac_o[1], 0);
    put(1, -2048, 2047, 1000);
    chk("corner A1", a_o[1], -4192256);
    chk("corner aac1", aac_o[1], 1);
    idle(5);
    chk("corner res", got_last[1], 2048);

    // LEN=1: every term loads, results on consecutive cycles.
    put(2, 5, 7, 1000);
    chk("len1 aac0", aac_o[2], 0);
    put(2, -3, 7, 1000);
    chk("len1 aac1", aac_o[2], 0);
    idle(1);
    chk("len1 res0", res_o[2], 35);
    idle(1);
    chk("len1 res1", res_o[2], -21);
    idle(3);

    // Random traffic on LEN=4 with a randomly stalling consumer.
    c0 = got_cnt[0];
    for (int i = 0; i < 120; i++) begin
      res_ready[0] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idle(1);
      put(0, rnd_op(), rnd_op(), 3);
    end
    res_ready[0] = 1'b1;
    idle(8);
    chk("rand0 frames", got_cnt[0] - c0, 30);

    // Random traffic on LEN=2 and LEN=1 with an always-ready consumer.
    c0 = got_cnt[1];
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      put(1, rnd_op(), rnd_op(), 1000);
    end
    idle(6);
    chk("rand1 frames", got_cnt[1] - c0, 10);
    c0 = got_cnt[2];
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      put(2, rnd_op(), rnd_op(), 1000);
    end
    idle(6);
    chk("rand2 frames", got_cnt[2] - c0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
